d_write_buffer: RTL and testbench

- Posted-write buffer between the write-through data cache memory port and main memory.
- Absorbs cache write-throughs into a FIFO and drains them to memory in the background, so a store completes in the same cycle when there is space.
- Serves cache read misses from memory, with store-to-load forwarding from pending entries.
- Memory-side ordering is preserved for writes; a read may bypass pending writes only when no pending entry has its address.

---
 rtl/d_wbuf_pkg.sv | 19 +
 rtl/d_write_buffer_if.sv | 29 ++
 rtl/wbuf_fifo.sv | 77 +++++++
 rtl/d_write_buffer.sv | 87 ++++++++
 tb/tb_d_write_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/d_wbuf_pkg.sv
// rtl/d_wbuf_pkg.sv - shared constants, FSM encoding and helpers for d_write_buffer
package d_wbuf_pkg;

  localparam int D_DEPTH = 4;
  localparam int D_AW    = 32;
  localparam int D_DW    = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/d_write_buffer_if.sv
// rtl/d_write_buffer_if.sv - cache-side and memory-side signal bundle for d_write_buffer
interface d_write_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_din;
  logic [DW-1:0] c_dout;
  logic          c_strobe;
  logic          c_rw;
  logic          c_ready;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_strobe;
  logic          mem_rw;
  logic          mem_ready;
  logic          wb_empty;

  modport slave (
    input  c_a, c_din, c_strobe, c_rw, mem_dout, mem_ready,
    output c_dout, c_ready, mem_a, mem_din, mem_strobe, mem_rw, wb_empty
  );

  modport master (
    output c_a, c_din, c_strobe, c_rw, mem_dout, mem_ready,
    input  c_dout, c_ready, mem_a, mem_din, mem_strobe, mem_rw, wb_empty
  );
endinterface

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - circular {addr,data} store with youngest-match lookup (WBUF_FWD_EN)
module wbuf_fifo
  import d_wbuf_pkg::*;
#(
  parameter int DEPTH = D_DEPTH,
  parameter int AW    = D_AW,
  parameter int DW    = D_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
`ifdef WBUF_FWD_EN
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
`endif
  output logic          full,
  output logic          empty
);
  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef WBUF_FWD_EN
  logic [PW-1:0] scan_idx;

  // Scan oldest to youngest so the last match wins; the head stays visible while draining.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (addr_q[scan_idx] == look_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[scan_idx];
      end
    end
  end
`endif

endmodule

// File: rtl/d_write_buffer.sv
// rtl/d_write_buffer.sv - posted-write buffer with read arbitration; forwarding under WBUF_FWD_EN
module d_write_buffer
  import d_wbuf_pkg::*;
#(
  parameter int DEPTH = D_DEPTH,
  parameter int AW    = D_AW,
  parameter int DW    = D_DW
) (
  input  logic              clk,
  input  logic              clr,
  d_write_buffer_if.slave   bus
);
  logic          push, pop, full, empty;
  logic          is_rd, fwd_ok, rd_done, rd_miss;
  logic [AW-1:0] head_addr, rd_addr;
  logic [DW-1:0] head_data, hit_data;
  logic [1:0]    state, state_n;

  assign is_rd = bus.c_strobe & ~bus.c_rw;
  assign push  = bus.c_strobe & bus.c_rw & ~full;
  assign pop   = (state == ST_WRITE) & bus.mem_ready;

`ifdef WBUF_FWD_EN
  logic hit;
  assign fwd_ok  = is_rd & hit;
  assign rd_miss = is_rd & ~hit;
`else
  // Without forwarding a read must never overtake buffered writes.
  assign hit_data = '0;
  assign fwd_ok   = 1'b0;
  assign rd_miss  = is_rd & empty;
`endif

  wbuf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_addr (bus.c_a),
    .push_data (bus.c_din),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
`ifdef WBUF_FWD_EN
    .look_addr (bus.c_a),
    .hit       (hit),
    .hit_data  (hit_data),
`endif
    .full      (full),
    .empty     (empty)
  );

  // A write landing in IDLE starts its drain on the next cycle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (rd_miss)             state_n = ST_READ;
        else if (!empty || push) state_n = ST_WRITE;
      end
      ST_WRITE: if (bus.mem_ready) state_n = ST_IDLE;
      ST_READ:  if (bus.mem_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
    end else begin
      state <= state_n;
      if ((state == ST_IDLE) && rd_miss) rd_addr <= bus.c_a;
    end
  end

  assign rd_done     = is_rd & (state == ST_READ) & bus.mem_ready;
  assign bus.c_ready = push | fwd_ok | rd_done;
  assign bus.c_dout  = fwd_ok ? hit_data : (rd_done ? bus.mem_dout : '0);

  assign bus.mem_strobe = (state == ST_WRITE) || (state == ST_READ);
  assign bus.mem_rw     = (state == ST_WRITE);
  assign bus.mem_a      = (state == ST_READ)  ? rd_addr :
                          (state == ST_WRITE) ? head_addr : '0;
  assign bus.mem_din    = (state == ST_WRITE) ? head_data : '0;
  assign bus.wb_empty   = empty && (state == ST_IDLE);

endmodule

// File: tb/tb_d_write_buffer.sv
// tb/tb_d_write_buffer.sv - directed scoreboard bench for d_write_buffer (WBUF_FWD_EN aware)
module tb_d_write_buffer;

  typedef struct packed {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  txn_t sb[$];
  txn_t e;

  always #5 clk = ~clk;

  d_write_buffer_if #(.AW(32), .DW(32)) bus ();

  d_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic txn_t mk(input logic rw, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.rw = rw;
    t.a  = a;
    t.d  = d;
    return t;
  endfunction

  task automatic sb_pop(output txn_t t);
    t = '0;
    chk("sb_nonempty", 64'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      t = sb.pop_front();
      chk("mem_rw", bus.mem_rw, t.rw);
      chk("mem_a", bus.mem_a, t.a);
      if (t.rw) chk("mem_din", bus.mem_din, t.d);
    end
  endtask

  task automatic cache_write(input logic [31:0] a, input logic [31:0] d, input logic exp_ready);
    bus.c_strobe = 1'b1;
    bus.c_rw     = 1'b1;
    bus.c_a      = a;
    bus.c_din    = d;
    #1;
    chk("wr_ready", bus.c_ready, exp_ready);
    chk("wr_dout_zero", bus.c_dout, 0);
    if (bus.c_ready === 1'b1) sb.push_back(mk(1'b1, a, d));
    tick();
    bus.c_strobe = 1'b0;
  endtask

  task automatic mem_serve(input int lat, input logic [31:0] rdata);
    txn_t t;
    int   n;
    n = 0;
    while (bus.mem_strobe !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("mem_strobe_seen", bus.mem_strobe, 1);
    if (bus.mem_strobe === 1'b1) begin
      sb_pop(t);
      repeat (lat) tick();
      if (!t.rw) chk("rd_stall", bus.c_ready, 0);
      bus.mem_dout  = rdata;
      bus.mem_ready = 1'b1;
      #1;
      if (!t.rw) begin
        chk("rd_ready", bus.c_ready, 1);
        chk("rd_dout", bus.c_dout, rdata);
      end
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_dout  = '0;
      if (!t.rw) bus.c_strobe = 1'b0;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (bus.wb_empty !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wb_empty_reached", bus.wb_empty, 1);
  endtask

  initial begin
    bus.c_a = '0; bus.c_din = '0; bus.c_strobe = 1'b0; bus.c_rw = 1'b0;
    bus.mem_dout = '0; bus.mem_ready = 1'b0;

    // Reset state
    tick(); tick();
    clr = 1'b0;
    #1;
    chk("rst_mem_strobe", bus.mem_strobe, 0);
    chk("rst_mem_rw", bus.mem_rw, 0);
    chk("rst_c_ready", bus.c_ready, 0);
    chk("rst_c_dout", bus.c_dout, 0);
    chk("rst_wb_empty", bus.wb_empty, 1);
    tick();

    // Single write drains after 3 wait cycles
    cache_write(32'h100, 32'hAAAA0001, 1'b1);
    chk("w1_strobe_next", bus.mem_strobe, 1);
    chk("w1_wb_empty_busy", bus.wb_empty, 0);
    mem_serve(3, 32'h0);
    chk("w1_wb_empty", bus.wb_empty, 1);

    // Fill to DEPTH, fifth write blocks until one drain retires
    for (int i = 0; i < 4; i++) cache_write(32'h10 + 32'(i * 4), 32'hF000 + 32'(i), 1'b1);
    bus.c_strobe = 1'b1; bus.c_rw = 1'b1; bus.c_a = 32'h20; bus.c_din = 32'hF004;
    #1;
    chk("full_block", bus.c_ready, 0);
    sb_pop(e);
    bus.mem_ready = 1'b1;
    #1;
    chk("full_no_pass", bus.c_ready, 0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("full_accept_after", bus.c_ready, 1);
    sb.push_back(mk(1'b1, 32'h20, 32'hF004));
    tick();
    bus.c_strobe = 1'b0;
    repeat (4) mem_serve(1, 32'h0);
    wait_empty();
    chk("fill_sb_drained", 64'(sb.size()), 0);

    // Two writes to one address, then a read of it while memory stalls
    cache_write(32'h200, 32'h1, 1'b1);
    cache_write(32'h200, 32'h2, 1'b1);
    bus.c_strobe = 1'b1; bus.c_rw = 1'b0; bus.c_a = 32'h200;
`ifdef WBUF_FWD_EN
    #1;
    chk("fwd_ready", bus.c_ready, 1);
    chk("fwd_dout_youngest", bus.c_dout, 32'h2);
    chk("fwd_mem_rw", bus.mem_rw, 1);
    tick();
    bus.c_strobe = 1'b0;
    #1;
    chk("idle_dout_zero", bus.c_dout, 0);
    mem_serve(0, 32'h0);
    mem_serve(0, 32'h0);
`else
    sb.push_back(mk(1'b0, 32'h200, 32'h0));
    #1;
    chk("nofwd_stall", bus.c_ready, 0);
    mem_serve(0, 32'h0);
    mem_serve(0, 32'h0);
    mem_serve(1, 32'h77);
`endif
    wait_empty();

    // Read miss while a write is pending in IDLE
    cache_write(32'h2FC, 32'h2F, 1'b1);
    cache_write(32'h300, 32'h33, 1'b1);
    bus.c_strobe = 1'b1; bus.c_rw = 1'b0; bus.c_a = 32'h400;
    #1;
    chk("byp_wait", bus.c_ready, 0);
    sb_pop(e);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
`ifdef WBUF_FWD_EN
    sb.push_front(mk(1'b0, 32'h400, 32'h0));
`else
    sb.push_back(mk(1'b0, 32'h400, 32'h0));
`endif
    mem_serve(1, 32'h55);
    mem_serve(1, 32'h55);
    wait_empty();
    chk("byp_sb_drained", 64'(sb.size()), 0);

    // Reset while draining with three entries queued
    cache_write(32'h500, 32'h50, 1'b1);
    cache_write(32'h504, 32'h54, 1'b1);
    cache_write(32'h508, 32'h58, 1'b1);
    chk("mid_drain_strobe", bus.mem_strobe, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_mem_strobe", bus.mem_strobe, 0);
    chk("clr_wb_empty", bus.wb_empty, 1);
    sb.delete();
    bus.c_strobe = 1'b1; bus.c_rw = 1'b0; bus.c_a = 32'h504;
    #1;
    chk("clr_no_forward", bus.c_ready, 0);
    sb.push_back(mk(1'b0, 32'h504, 32'h0));
    mem_serve(1, 32'h99);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
